// File: rtl/spi_responder.sv
// SPI mode-0 target port: pins are oversampled on clk, MOSI bytes go to an RX FIFO,
// and MISO bytes come from a TX FIFO, with a show-ahead byte-side handshake.
module spi_responder #(
    parameter int         RX_DEPTH   = 4,
    parameter int         TX_DEPTH   = 4,
    parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       spi_sck,
    input  logic       spi_cs,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] rx_dout,
    output logic       rx_data_present,
    input  logic       rx_ren,
    input  logic [7:0] tx_din,
    input  logic       tx_wen,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       overrun,
    output logic       underrun,
    input  logic       err_clr
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam logic [RX_AW:0] RX_PTR_ONE = {{RX_AW{1'b0}}, 1'b1};
    localparam logic [TX_AW:0] TX_PTR_ONE = {{TX_AW{1'b0}}, 1'b1};

    // Pin synchronizers: two flops for metastability, a third on SCK/CS for edge detect.
    logic [2:0] sck_sync_q;
    logic [2:0] cs_sync_q;
    logic [1:0] mosi_sync_q;

    always_ff @(posedge clk) begin
        sck_sync_q  <= {sck_sync_q[1:0], spi_sck};
        cs_sync_q   <= {cs_sync_q[1:0], spi_cs};
        mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
    end

    logic sck_rise;
    logic sck_fall;
    logic cs_fall;
    logic cs_rise;
    logic mosi_s;

    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
    assign mosi_s   = mosi_sync_q[1];

    // FIFO storage and pointers (one extra wrap bit each)
    logic [7:0]     rx_mem_q [RX_DEPTH];
    logic [7:0]     tx_mem_q [TX_DEPTH];
    logic [RX_AW:0] rx_wr_q;
    logic [RX_AW:0] rx_rd_q;
    logic [TX_AW:0] tx_wr_q;
    logic [TX_AW:0] tx_rd_q;

    logic rx_empty;
    logic rx_full;
    logic rx_pop;
    logic rx_wr_en;
    logic tx_pop;
    logic tx_wr_en;

    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                      (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[TX_AW] != tx_rd_q[TX_AW]) &&
                      (tx_wr_q[TX_AW-1:0] == tx_rd_q[TX_AW-1:0]);

    // Frame control state
    logic       active_q,    active_d;
    logic [2:0] bitcnt_q,    bitcnt_d;
    logic [6:0] rx_shift_q,  rx_shift_d;
    logic [7:0] tx_shift_q,  tx_shift_d;
    logic       rx_push_q,   rx_push_d;
    logic [7:0] rx_byte_q,   rx_byte_d;
    logic       dflt_pend_q, dflt_pend_d;
    logic       overrun_q,   overrun_d;
    logic       underrun_q,  underrun_d;

    logic       tx_load;
    logic       und_set;
    logic       ov_set;
    logic [7:0] load_byte;

    assign load_byte = tx_empty ? DEFAULT_TX : tx_mem_q[tx_rd_q[TX_AW-1:0]];

    // A default byte loaded on an SCK fall is only a prefetch; underrun is recorded
    // once its first bit is actually clocked by the next SCK rise.
    always_comb begin
        active_d    = active_q;
        bitcnt_d    = bitcnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_push_d   = 1'b0;
        rx_byte_d   = rx_byte_q;
        dflt_pend_d = dflt_pend_q;
        tx_load     = 1'b0;
        und_set     = 1'b0;
        if (cs_rise) begin
            active_d    = 1'b0;
            bitcnt_d    = 3'd0;
            dflt_pend_d = 1'b0;
        end else if (cs_fall) begin
            active_d    = 1'b1;
            bitcnt_d    = 3'd0;
            tx_load     = 1'b1;
            tx_shift_d  = load_byte;
            und_set     = tx_empty;
            dflt_pend_d = 1'b0;
        end else if (active_q && sck_rise) begin
            rx_shift_d = {rx_shift_q[5:0], mosi_s};
            bitcnt_d   = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
                rx_push_d = 1'b1;
                rx_byte_d = {rx_shift_q, mosi_s};
            end
            if (dflt_pend_q) begin
                und_set     = 1'b1;
                dflt_pend_d = 1'b0;
            end
        end else if (active_q && sck_fall) begin
            if (bitcnt_q == 3'd0) begin
                tx_load     = 1'b1;
                tx_shift_d  = load_byte;
                dflt_pend_d = tx_empty;
            end else begin
                tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
        end
    end

    assign rx_pop   = rx_ren & ~rx_empty;
    assign rx_wr_en = rx_push_q & (~rx_full | rx_pop);
    assign ov_set   = rx_push_q & rx_full & ~rx_ren;
    assign tx_pop   = tx_load & ~tx_empty;
    assign tx_wr_en = tx_wen & (~tx_full | tx_pop);

    always_comb begin
        overrun_d  = overrun_q;
        underrun_d = underrun_q;
        if (err_clr) begin
            overrun_d  = 1'b0;
            underrun_d = 1'b0;
        end
        if (ov_set) begin
            overrun_d = 1'b1;
        end
        if (und_set) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            active_q    <= 1'b0;
            bitcnt_q    <= 3'd0;
            tx_shift_q  <= 8'h00;
            rx_push_q   <= 1'b0;
            dflt_pend_q <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
        end else begin
            active_q    <= active_d;
            bitcnt_q    <= bitcnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_push_q   <= rx_push_d;
            dflt_pend_q <= dflt_pend_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
            if (rx_wr_en) rx_wr_q <= rx_wr_q + RX_PTR_ONE;
            if (rx_pop)   rx_rd_q <= rx_rd_q + RX_PTR_ONE;
            if (tx_wr_en) tx_wr_q <= tx_wr_q + TX_PTR_ONE;
            if (tx_pop)   tx_rd_q <= tx_rd_q + TX_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        rx_shift_q <= rx_shift_d;
        rx_byte_q  <= rx_byte_d;
        if (rx_wr_en) rx_mem_q[rx_wr_q[RX_AW-1:0]] <= rx_byte_q;
        if (tx_wr_en) tx_mem_q[tx_wr_q[TX_AW-1:0]] <= tx_din;
    end

    assign spi_miso        = tx_shift_q[7];
    assign spi_miso_oe     = active_q;
    assign rx_data_present = ~rx_empty;
    assign rx_dout         = rx_empty ? 8'h00 : rx_mem_q[rx_rd_q[RX_AW-1:0]];
    assign overrun         = overrun_q;
    assign underrun        = underrun_q;

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: drives SPI mode-0 frames at clk/8 and compares against
// a queue-based model of the FIFOs, sticky flags and the MISO byte stream.
module tb_spi_responder;

    localparam int         RXD  = 4;
    localparam int         TXD  = 4;
    localparam logic [7:0] DFLT = 8'hFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sck;
    logic       spi_cs;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] rx_dout;
    logic       rx_data_present;
    logic       rx_ren;
    logic [7:0] tx_din;
    logic       tx_wen;
    logic       tx_full;
    logic       tx_empty;
    logic       overrun;
    logic       underrun;
    logic       err_clr;

    always #5 clk = ~clk;

    spi_responder #(.RX_DEPTH(RXD), .TX_DEPTH(TXD), .DEFAULT_TX(DFLT)) dut (
        .clk(clk), .Rst(rst),
        .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .rx_dout(rx_dout), .rx_data_present(rx_data_present), .rx_ren(rx_ren),
        .tx_din(tx_din), .tx_wen(tx_wen), .tx_full(tx_full), .tx_empty(tx_empty),
        .overrun(overrun), .underrun(underrun), .err_clr(err_clr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_rx[$];
    logic [7:0] m_tx[$];
    bit         m_ov;
    bit         m_un;
    logic [7:0] f_bytes[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".rx_present"}, rx_data_present, m_rx.size() > 0);
        chk({tag, ".rx_dout"}, rx_dout, (m_rx.size() > 0) ? m_rx[0] : 8'h00);
        chk({tag, ".tx_full"}, tx_full, m_tx.size() == TXD);
        chk({tag, ".tx_empty"}, tx_empty, m_tx.size() == 0);
        chk({tag, ".overrun"}, overrun, m_ov);
        chk({tag, ".underrun"}, underrun, m_un);
    endtask

    task automatic tx_push(input logic [7:0] b);
        @(negedge clk);
        tx_din = b;
        tx_wen = 1'b1;
        @(negedge clk);
        tx_wen = 1'b0;
        if (m_tx.size() < TXD) m_tx.push_back(b);
    endtask

    task automatic rx_read();
        check_status("read");
        @(negedge clk);
        rx_ren = 1'b1;
        @(negedge clk);
        rx_ren = 1'b0;
        if (m_rx.size() > 0) void'(m_rx.pop_front());
    endtask

    task automatic clear_errs();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_ov = 1'b0;
        m_un = 1'b0;
    endtask

    // One SCK period of 8 clk; MISO is sampled just before the rising edge.
    task automatic spi_bit(input bit b, input bit ren_here, input bit lat_here, output bit m);
        spi_mosi = b;
        repeat (4) @(negedge clk);
        m = spi_miso;
        spi_sck = 1'b1;
        repeat (3) @(negedge clk);
        if (lat_here) chk("rx_present_lat3", rx_data_present, 1'b0);
        if (ren_here) rx_ren = 1'b1;
        @(negedge clk);
        rx_ren = 1'b0;
        if (lat_here) chk("rx_present_lat4", rx_data_present, 1'b1);
        spi_sck = 1'b0;
    endtask

    task automatic rx_model_push(input logic [7:0] b, input bit ren);
        if (ren && m_rx.size() > 0) void'(m_rx.pop_front());
        if (m_rx.size() < RXD) m_rx.push_back(b);
        else m_ov = 1'b1;
    endtask

    // Sends nbits of f_bytes in one CS assertion. Each started byte is sourced from
    // the TX queue or the default; one further byte is fetched after every full byte.
    task automatic spi_frame(input int nbits, input bit ren_last, input bit lat_chk);
        int         nloads;
        int         nstart;
        int         nfull;
        logic [7:0] exp_tx[$];
        bit         dflt[$];
        logic [7:0] cur;
        logic [7:0] got;
        bit         m;
        nloads = 1 + nbits / 8;
        nstart = (nbits == 0) ? 1 : 1 + (nbits - 1) / 8;
        nfull  = nbits / 8;
        for (int i = 0; i < nloads; i++) begin
            if (m_tx.size() > 0) begin
                exp_tx.push_back(m_tx.pop_front());
                dflt.push_back(1'b0);
            end else begin
                exp_tx.push_back(DFLT);
                dflt.push_back(1'b1);
            end
        end
        for (int i = 0; i < nstart; i++) if (dflt[i]) m_un = 1'b1;
        @(negedge clk);
        spi_cs = 1'b0;
        repeat (5) @(negedge clk);
        chk("miso_oe_on", spi_miso_oe, 1'b1);
        got = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            cur = f_bytes[k / 8];
            spi_bit(cur[7 - (k % 8)], ren_last && (k == 8 * nfull - 1), lat_chk && (k == 7), m);
            got = {got[6:0], m};
            if (k % 8 == 7) begin
                chk("miso_byte", got, exp_tx[k / 8]);
                rx_model_push(cur, ren_last && (k == 8 * nfull - 1));
            end
        end
        repeat (4) @(negedge clk);
        spi_cs = 1'b1;
        repeat (6) @(negedge clk);
        chk("miso_oe_off", spi_miso_oe, 1'b0);
        check_status("frame");
    endtask

    initial begin
        bit dummy;
        int nb;
        int nbits;
        rst = 1'b1; spi_sck = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
        rx_ren = 1'b0; tx_din = 8'h00; tx_wen = 1'b0; err_clr = 1'b0;
        m_ov = 1'b0; m_un = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_miso", spi_miso, 1'b0);
        chk("rst_oe", spi_miso_oe, 1'b0);
        check_status("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Basic exchange
        tx_push(8'hA5);
        check_status("basic_pushed");
        f_bytes = '{8'h3C};
        spi_frame(8, 1'b0, 1'b1);
        chk("basic_rx", rx_dout, 8'h3C);
        chk("basic_tx_empty", tx_empty, 1'b1);
        chk("basic_underrun", underrun, 1'b0);
        rx_read();

        // Underrun
        f_bytes = '{8'h01, 8'h02};
        spi_frame(16, 1'b0, 1'b0);
        chk("underrun_set", underrun, 1'b1);
        clear_errs();
        chk("underrun_clr", underrun, 1'b0);
        rx_read();
        rx_read();

        // Overrun
        f_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        spi_frame(40, 1'b0, 1'b0);
        chk("overrun_set", overrun, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            chk("overrun_order", rx_dout, i);
            rx_read();
        end
        chk("overrun_drained", rx_data_present, 1'b0);
        clear_errs();

        // Push and pop in the same cycle while RX is full
        f_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        spi_frame(32, 1'b0, 1'b0);
        f_bytes = '{8'h77};
        spi_frame(8, 1'b1, 1'b0);
        chk("simul_overrun", overrun, 1'b0);
        chk("simul_head", rx_dout, 8'h02);
        repeat (4) rx_read();
        clear_errs();

        // Aborted partial frame then a full one
        f_bytes = '{8'hF0};
        spi_frame(5, 1'b0, 1'b0);
        f_bytes = '{8'h81};
        spi_frame(8, 1'b0, 1'b0);
        chk("abort_rx", rx_dout, 8'h81);
        rx_read();
        chk("abort_single", rx_data_present, 1'b0);
        clear_errs();

        // TX full boundary
        for (int i = 0; i < TXD + 1; i++) tx_push(8'h10 + 8'(i));
        check_status("tx_full");

        // Reset mid-frame
        f_bytes = '{8'h11};
        spi_frame(8, 1'b0, 1'b0);
        tx_push(8'h22);
        @(negedge clk);
        spi_cs = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b0, 1'b0, dummy);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_miso", spi_miso, 1'b0);
        chk("mid_rst_oe", spi_miso_oe, 1'b0);
        m_rx.delete(); m_tx.delete(); m_ov = 1'b0; m_un = 1'b0;
        check_status("mid_rst");
        spi_cs = 1'b1;
        repeat (6) @(negedge clk);
        f_bytes = '{8'h5A};
        spi_frame(8, 1'b0, 1'b0);
        chk("rst_then_5a", rx_dout, 8'h5A);
        rx_read();
        clear_errs();

        // Randomized traffic
        for (int it = 0; it < 20; it++) begin
            int npush;
            npush = $urandom_range(0, 3);
            for (int i = 0; i < npush; i++) tx_push(8'($urandom));
            nb = $urandom_range(0, 3);
            nbits = 8 * nb + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
            if (nbits == 0) nbits = 8;
            f_bytes.delete();
            for (int i = 0; i <= nbits / 8; i++) f_bytes.push_back(8'($urandom));
            spi_frame(nbits, (nbits >= 8) && ($urandom_range(0, 2) == 0), 1'b0);
            for (int i = $urandom_range(0, 3); i > 0; i--) rx_read();
            if ($urandom_range(0, 3) == 0) begin
                clear_errs();
                check_status("rand_clr");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
